// File: rtl/sram_frame_reader.sv
// Scan-out engine: prefetches front-buffer pixels from SRAM into a small FIFO for the VGA path,
// and interleaves single-word back-buffer writes. Reads below the low-water mark pre-empt writes.
module sram_frame_reader #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          FIFO_DEPTH = 16,
  parameter int          LOW_WATER  = 4,
  parameter logic [19:0] BUF1_BASE  = 20'h80000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_frame_start,
  input  logic        i_front_sel,
  input  logic        i_pix_pop,
  output logic [15:0] o_pix_data,
  output logic        o_pix_valid,
  output logic        o_underflow,
  input  logic        i_wr_req,
  input  logic [18:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_wr_ack,
  output logic [19:0] o_sram_address,
  inout  wire  [15:0] io_sram_dq,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n,
  output logic        o_sram_ub_n,
  output logic        o_sram_lb_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [18:0] PIX_TOTAL = 19'(H_RES * V_RES);
  localparam logic [CW:0] LVL_MAX   = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LVL_LOW = CW'(LOW_WATER);

  typedef enum logic [1:0] {IDLE, RD, WR0, WR1} state_t;

  state_t         r_state, w_next;
  logic [15:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [CW-1:0]  r_count;
  logic [18:0]    r_fetch_ptr;
  logic           r_front, r_armed, r_underflow;
  logic [19:0]    r_addr;
  logic [15:0]    r_wdata;

  logic           w_push, w_pop, w_rd_allowed, w_low;
  logic [CW:0]    w_level;
  logic [19:0]    w_rd_addr, w_wr_addr;

  // A read driven this cycle is captured at the coming edge, so it already owns a FIFO slot.
  assign w_level      = {1'b0, r_count} + {{CW{1'b0}}, (r_state == RD)};
  assign w_rd_allowed = r_armed && (r_fetch_ptr < PIX_TOTAL) && (w_level < LVL_MAX);
  assign w_low        = (r_count < LVL_LOW);
  assign w_push       = (r_state == RD) && !i_frame_start;
  assign w_pop        = i_pix_pop && (r_count != '0);
  assign w_rd_addr    = (r_front ? BUF1_BASE : 20'h0) + {1'b0, r_fetch_ptr};
  assign w_wr_addr    = (r_front ? 20'h0 : BUF1_BASE) | {1'b0, i_wr_addr};

  always_comb begin
    w_next = IDLE;
    case (r_state)
      WR0:     w_next = WR1;
      WR1:     w_next = IDLE;
      default: begin
        if (i_frame_start)                      w_next = IDLE;
        else if (w_rd_allowed && (w_low || !i_wr_req)) w_next = RD;
        else if (i_wr_req)                      w_next = WR0;
        else                                    w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_fetch_ptr <= '0;
      r_front     <= 1'b0;
      r_armed     <= 1'b0;
      r_underflow <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_underflow <= r_underflow | (i_pix_pop && (r_count == '0));
      if (w_next == RD) begin
        r_addr      <= w_rd_addr;
        r_fetch_ptr <= r_fetch_ptr + 19'd1;
      end else if (w_next == WR0) begin
        r_addr  <= w_wr_addr;
        r_wdata <= i_wr_data;
      end
      // A new frame discards queued and in-flight pixels; a write in progress finishes.
      if (i_frame_start) begin
        r_front     <= i_front_sel;
        r_armed     <= 1'b1;
        r_fetch_ptr <= '0;
        r_wptr      <= '0;
        r_rptr      <= '0;
        r_count     <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + AW'(1);
        if (w_pop)  r_rptr <= r_rptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= io_sram_dq;
  end

  assign o_pix_valid    = (r_count != '0);
  assign o_pix_data     = o_pix_valid ? r_mem[r_rptr] : 16'h0000;
  assign o_underflow    = r_underflow;
  assign o_wr_ack       = (r_state == WR1);
  assign o_sram_address = r_addr;
  assign o_sram_ce_n    = (r_state == IDLE);
  assign o_sram_oe_n    = (r_state != RD);
  assign o_sram_we_n    = (r_state != WR0);
  assign o_sram_ub_n    = (r_state == IDLE);
  assign o_sram_lb_n    = (r_state == IDLE);
  assign io_sram_dq     = ((r_state == WR0) || (r_state == WR1)) ? r_wdata : 16'hzzzz;

endmodule

// File: tb/tb_sram_frame_reader.sv
`timescale 1ns/1ps
// Directed bench for sram_frame_reader on a reduced 16x8 frame with a behavioural SRAM.
module tb_sram_frame_reader;
  localparam int TOTAL = 16 * 8;

  logic        clk = 1'b0;
  logic        reset, frame_start, front_sel, pix_pop, wr_req;
  logic [18:0] wr_addr;
  logic [15:0] wr_data;
  logic [15:0] pix_data;
  logic        pix_valid, underflow, wr_ack;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Buffer 0 word k holds k; buffer 1 word k holds ~k.
  function automatic logic [15:0] model(input logic [19:0] a);
    return a[19] ? ~a[15:0] : a[15:0];
  endfunction

  assign sram_dq = (!ce_n && !oe_n && we_n) ? model(sram_addr) : 16'hzzzz;

  sram_frame_reader #(.H_RES(16), .V_RES(8), .FIFO_DEPTH(16), .LOW_WATER(4),
                      .BUF1_BASE(20'h80000)) dut (
    .i_clk(clk), .i_reset(reset), .i_frame_start(frame_start), .i_front_sel(front_sel),
    .i_pix_pop(pix_pop), .o_pix_data(pix_data), .o_pix_valid(pix_valid),
    .o_underflow(underflow), .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_ack(wr_ack), .o_sram_address(sram_addr), .io_sram_dq(sram_dq),
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_ub_n(ub_n), .o_sram_lb_n(lb_n));

  task automatic test_reset();
    int rd_cycles;
    reset = 1; frame_start = 0; front_sel = 0; pix_pop = 0;
    wr_req = 0; wr_addr = '0; wr_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pix_valid, pix_data, underflow, wr_ack} !== 19'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {pix_valid, pix_data, underflow, wr_ack});
    end
    checks++;
    if ({sram_addr, ce_n, oe_n, we_n, ub_n, lb_n} !== {20'h0, 5'b11111}) begin
      errors++; $display("FAIL reset_sram got %h want %h", {sram_addr, ce_n, oe_n, we_n, ub_n, lb_n}, {20'h0, 5'b11111});
    end
    reset = 0;
    rd_cycles = 0;
    repeat (6) begin @(negedge clk); if (oe_n === 1'b0) rd_cycles++; end
    checks++;
    if (rd_cycles != 0) begin
      errors++; $display("FAIL reads_before_frame got %0d want 0", rd_cycles);
    end
  endtask

  task automatic test_fill();
    int rd_cycles, bad_addr;
    frame_start = 1; front_sel = 0;
    @(negedge clk); frame_start = 0;
    rd_cycles = 0; bad_addr = 0;
    repeat (40) begin
      @(negedge clk);
      if (oe_n === 1'b0) begin
        if (sram_addr !== 20'(rd_cycles)) bad_addr++;
        rd_cycles++;
      end
    end
    checks++;
    if (rd_cycles != 16) begin errors++; $display("FAIL fill_reads got %0d want 16", rd_cycles); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL fill_addr got %0d bad want 0", bad_addr); end
    checks++;
    if (pix_valid !== 1'b1 || pix_data !== 16'h0000) begin
      errors++; $display("FAIL fill_head got v=%b d=%h want v=1 d=0000", pix_valid, pix_data);
    end
  endtask

  task automatic test_stream();
    int exp_pix, n, rd_cycles;
    bit phase;
    exp_pix = 0; n = 0; phase = 0;
    while (exp_pix < TOTAL && n < 2000) begin
      phase = ~phase;
      pix_pop = 0;
      if (phase && pix_valid) begin
        checks++;
        if (pix_data !== 16'(exp_pix)) begin
          errors++; $display("FAIL stream_pixel got %h want %h", pix_data, 16'(exp_pix));
        end
        pix_pop = 1;
        exp_pix++;
      end
      @(negedge clk); n++;
    end
    pix_pop = 0;
    checks++;
    if (exp_pix != TOTAL) begin errors++; $display("FAIL stream_count got %0d want %0d", exp_pix, TOTAL); end
    rd_cycles = 0;
    repeat (20) begin @(negedge clk); if (oe_n === 1'b0) rd_cycles++; end
    checks++;
    if (rd_cycles != 0 || pix_valid !== 1'b0) begin
      errors++; $display("FAIL end_of_frame got reads=%0d v=%b want reads=0 v=0", rd_cycles, pix_valid);
    end
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL stream_underflow got %b want 0", underflow); end
  endtask

  task automatic test_write_priority();
    int rd_cycles, n;
    frame_start = 1; front_sel = 0;
    wr_req = 1; wr_addr = 19'd5; wr_data = 16'hBEEF;
    @(negedge clk); frame_start = 0;
    rd_cycles = 0; n = 0;
    while (we_n !== 1'b0 && n < 30) begin
      if (oe_n === 1'b0) rd_cycles++;
      @(negedge clk); n++;
    end
    checks++;
    if (we_n !== 1'b0) begin errors++; $display("FAIL wr_grant timeout we_n=%b want 0", we_n); end
    checks++;
    if (rd_cycles != 5) begin errors++; $display("FAIL low_water_reads got %0d want 5", rd_cycles); end
    checks++;
    if (sram_addr !== 20'h80005 || sram_dq !== 16'hBEEF || oe_n !== 1'b1) begin
      errors++; $display("FAIL wr0_bus got a=%h d=%h oe=%b want a=80005 d=beef oe=1", sram_addr, sram_dq, oe_n);
    end
    @(negedge clk);
    checks++;
    if (we_n !== 1'b1 || wr_ack !== 1'b1 || sram_dq !== 16'hBEEF) begin
      errors++; $display("FAIL wr1_ack got we=%b ack=%b d=%h want we=1 ack=1 d=beef", we_n, wr_ack, sram_dq);
    end
    wr_req = 0;
    @(negedge clk);
    checks++;
    if (wr_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse got %b want 0", wr_ack); end
    // FIFO full: write goes straight through, out-of-range offset is not clipped.
    repeat (30) @(negedge clk);
    wr_req = 1; wr_addr = 19'h7FFFF; wr_data = 16'h1234;
    n = 0;
    while (we_n !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (sram_addr !== 20'hFFFFF || sram_dq !== 16'h1234 || we_n !== 1'b0) begin
      errors++; $display("FAIL full_write got a=%h d=%h we=%b want a=fffff d=1234 we=0", sram_addr, sram_dq, we_n);
    end
    @(negedge clk); wr_req = 0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (pix_data !== 16'(k) || pix_valid !== 1'b1) begin
        errors++; $display("FAIL post_write_pixel got %h v=%b want %h", pix_data, pix_valid, 16'(k));
      end
      pix_pop = 1;
      @(negedge clk);
    end
    pix_pop = 0;
  endtask

  task automatic test_frame_switch();
    int n;
    pix_pop = 1;
    repeat (4) @(negedge clk);
    pix_pop = 0; frame_start = 1; front_sel = 1;
    @(negedge clk); frame_start = 0;
    checks++;
    if (pix_valid !== 1'b0 || pix_data !== 16'h0000) begin
      errors++; $display("FAIL flush got v=%b d=%h want v=0 d=0000", pix_valid, pix_data);
    end
    n = 0;
    while (oe_n !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (sram_addr !== 20'h80000 || oe_n !== 1'b0) begin
      errors++; $display("FAIL first_read_buf1 got a=%h oe=%b want a=80000 oe=0", sram_addr, oe_n);
    end
    n = 0;
    while (pix_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (pix_data !== 16'hFFFF) begin errors++; $display("FAIL buf1_pixel0 got %h want ffff", pix_data); end
    pix_pop = 1; @(negedge clk); pix_pop = 0;
    checks++;
    if (pix_data !== 16'hFFFE) begin errors++; $display("FAIL buf1_pixel1 got %h want fffe", pix_data); end
  endtask

  task automatic test_underflow();
    reset = 1; @(negedge clk); reset = 0;
    pix_pop = 1;
    @(negedge clk);
    checks++;
    if (underflow !== 1'b1 || pix_data !== 16'h0000 || pix_valid !== 1'b0) begin
      errors++; $display("FAIL underflow_set got u=%b d=%h v=%b want u=1 d=0000 v=0", underflow, pix_data, pix_valid);
    end
    pix_pop = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %b want 1", underflow); end
    reset = 1; @(negedge clk);
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got %b want 0", underflow); end
    reset = 0;
  endtask

  task automatic test_reset_during_write();
    int n, acks;
    wr_req = 1; wr_addr = 19'd3; wr_data = 16'hAAAA;
    n = 0;
    while (we_n !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (we_n !== 1'b0 || sram_addr !== 20'h80003) begin
      errors++; $display("FAIL abort_grant got we=%b a=%h want we=0 a=80003", we_n, sram_addr);
    end
    reset = 1;
    @(negedge clk);
    checks++;
    if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111 || wr_ack !== 1'b0) begin
      errors++; $display("FAIL abort_bus got ctl=%b ack=%b want ctl=11111 ack=0", {ce_n, oe_n, we_n, ub_n, lb_n}, wr_ack);
    end
    wr_req = 0; reset = 0;
    acks = 0;
    repeat (4) begin @(negedge clk); if (wr_ack === 1'b1) acks++; end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL abort_no_ack got %0d want 0", acks); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_write_priority();
    test_frame_switch();
    test_underflow();
    test_reset_during_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
